// File: rtl/forwarding_scoreboard.sv
// -----------------------------------------------------------------------------
// forwarding_scoreboard
//
// Tracks the destination tags of the last DEPTH instructions issued out of ID
// and decides, for each source operand of the instruction currently in ID,
// where its value should come from (a forwarding stage or the register file).
// It also raises a load-use stall when the youngest producer of a source is a
// load whose data is not yet available.
//
// Tag pipeline: entry 0 is EX, entry 1 is MEM, entry 2 is WB, and so on.
// Every clock edge the entries shift one stage older. The ID instruction
// enters entry 0 unless it is stalled, flushed or not valid, in which case a
// bubble enters instead.
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   asynchronous, active-low reset (clears all entries)
//   id_valid        in   ID holds a real instruction
//   id_rs           in   NUM_SRC x 5-bit source register addresses
//   id_rs_used      in   per-source "operand is actually read" flags
//   id_rd           in   destination register of the ID instruction
//   id_reg_write    in   ID instruction writes id_rd
//   id_is_load      in   ID instruction is a load
//   flush           in   kill the ID instruction (it never enters EX)
//   forward         out  NUM_SRC x SEL_W select; DEPTH-i for entry i, 0 = RF
//   stall           out  hold PC/IF/ID and insert a bubble into EX
//   inflight_writes out  count of tracked entries that will write a register
// -----------------------------------------------------------------------------
module forwarding_scoreboard #(
  parameter int  NUM_SRC    = 2,
  parameter int  DEPTH      = 3,
  parameter int  LOAD_READY = 1,
  localparam int SEL_W      = $clog2(DEPTH + 1),
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [NUM_SRC*5-1:0]     id_rs,
  input  logic [NUM_SRC-1:0]       id_rs_used,
  input  logic [4:0]               id_rd,
  input  logic                     id_reg_write,
  input  logic                     id_is_load,
  input  logic                     flush,
  output logic [NUM_SRC*SEL_W-1:0] forward,
  output logic                     stall,
  output logic [CNT_W-1:0]         inflight_writes
);

  // Tag pipeline state, one bit/field per stage.
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] wr_q,    wr_d;
  logic [DEPTH-1:0] ld_q,    ld_d;
  logic [4:0]       rd_q [DEPTH];
  logic [4:0]       rd_d [DEPTH];

  // Per-source "youngest producer is a load that is not ready yet".
  logic [NUM_SRC-1:0] src_stall;
  logic               issue;

  // ---------------------------------------------------------------------------
  // Operand matching. The stage loop runs from oldest to youngest so the
  // youngest match overwrites older ones; that single entry decides both the
  // forward select and whether the source stalls (an older matching load is
  // irrelevant once a younger writer of the same register exists).
  // ---------------------------------------------------------------------------
  always_comb begin
    forward   = '0;
    src_stall = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (id_rs_used[s] && (id_rs[5*s +: 5] != 5'd0) &&
            valid_q[i] && wr_q[i] && (rd_q[i] == id_rs[5*s +: 5])) begin
          forward[SEL_W*s +: SEL_W] = SEL_W'(DEPTH - i);
          src_stall[s]              = ld_q[i] && (i < LOAD_READY);
        end
      end
    end
  end

  assign stall = id_valid && (|src_stall);

  // ---------------------------------------------------------------------------
  // Next-state: shift every entry one stage older, then fill entry 0 with
  // either the issuing instruction or a bubble. Writes to x0 enter with wr
  // cleared so they never match and are never counted.
  // ---------------------------------------------------------------------------
  assign issue = id_valid && !stall && !flush;

  always_comb begin
    valid_d = '0;
    wr_d    = '0;
    ld_d    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_d[i] = 5'd0;
    end

    valid_d[0] = issue;
    rd_d[0]    = issue ? id_rd : 5'd0;
    wr_d[0]    = issue && id_reg_write && (id_rd != 5'd0);
    ld_d[0]    = issue && id_is_load;

    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      rd_d[i]    = rd_q[i-1];
      wr_d[i]    = wr_q[i-1];
      ld_d[i]    = ld_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset clears every entry to a bubble immediately, without
  // waiting for a clock edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      wr_q    <= '0;
      ld_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i] <= 5'd0;
      end
    end else begin
      valid_q <= valid_d;
      wr_q    <= wr_d;
      ld_q    <= ld_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i] <= rd_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Population count of entries that will still write a register.
  // ---------------------------------------------------------------------------
  always_comb begin
    inflight_writes = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && wr_q[i]) begin
        inflight_writes = inflight_writes + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_forwarding_scoreboard
//
// Directed, table-driven bench for forwarding_scoreboard. Instance "dut" uses
// the default parameters (NUM_SRC=2, DEPTH=3, LOAD_READY=1) and is driven by a
// cycle-by-cycle vector table; instance "dut5" uses NUM_SRC=3, DEPTH=5,
// LOAD_READY=3 and is exercised by a short hand-written sequence. Reset
// behaviour (including an asynchronous mid-cycle reset) is checked by hand.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_forwarding_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Default-parameter instance signals.
  logic       a_valid;
  logic [9:0] a_rs;
  logic [1:0] a_used;
  logic [4:0] a_rd;
  logic       a_rw;
  logic       a_ld;
  logic       a_fl;
  logic [3:0] a_fwd;
  logic       a_stall;
  logic [1:0] a_cnt;

  // DEPTH=5 / LOAD_READY=3 / NUM_SRC=3 instance signals.
  logic        b_valid;
  logic [14:0] b_rs;
  logic [2:0]  b_used;
  logic [4:0]  b_rd;
  logic        b_rw;
  logic        b_ld;
  logic        b_fl;
  logic [8:0]  b_fwd;
  logic        b_stall;
  logic [2:0]  b_cnt;

  forwarding_scoreboard dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (a_valid),
    .id_rs           (a_rs),
    .id_rs_used      (a_used),
    .id_rd           (a_rd),
    .id_reg_write    (a_rw),
    .id_is_load      (a_ld),
    .flush           (a_fl),
    .forward         (a_fwd),
    .stall           (a_stall),
    .inflight_writes (a_cnt)
  );

  forwarding_scoreboard #(
    .NUM_SRC    (3),
    .DEPTH      (5),
    .LOAD_READY (3)
  ) dut5 (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (b_valid),
    .id_rs           (b_rs),
    .id_rs_used      (b_used),
    .id_rd           (b_rd),
    .id_reg_write    (b_rw),
    .id_is_load      (b_ld),
    .flush           (b_fl),
    .forward         (b_fwd),
    .stall           (b_stall),
    .inflight_writes (b_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       v;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] used;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       fl;
    logic [1:0] f0;
    logic [1:0] f1;
    logic       st;
    logic [1:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(input int v, input int rs0, input int rs1, input int used,
                               input int rd, input int rw, input int ld, input int fl,
                               input int f0, input int f1, input int st, input int cnt);
    vec_t r;
    r.v    = 1'(v);
    r.rs0  = 5'(rs0);
    r.rs1  = 5'(rs1);
    r.used = 2'(used);
    r.rd   = 5'(rd);
    r.rw   = 1'(rw);
    r.ld   = 1'(ld);
    r.fl   = 1'(fl);
    r.f0   = 2'(f0);
    r.f1   = 2'(f1);
    r.st   = 1'(st);
    r.cnt  = 2'(cnt);
    return r;
  endfunction

  task automatic drive_a(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [1:0] used, input logic [4:0] rd, input logic rw,
                         input logic ld, input logic fl);
    a_valid = v;
    a_rs    = {rs1, rs0};
    a_used  = used;
    a_rd    = rd;
    a_rw    = rw;
    a_ld    = ld;
    a_fl    = fl;
  endtask

  task automatic drive_b(input logic v, input logic [14:0] rs, input logic [2:0] used,
                         input logic [4:0] rd, input logic rw, input logic ld);
    b_valid = v;
    b_rs    = rs;
    b_used  = used;
    b_rd    = rd;
    b_rw    = rw;
    b_ld    = ld;
    b_fl    = 1'b0;
  endtask

  initial begin
    //       v rs0 rs1 u  rd rw ld fl | f0 f1 st cnt
    // add x5, then read x5 as it ages EX -> MEM -> WB -> gone
    tbl.push_back(row(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 5, 0, 1, 0, 0, 0, 0, 3, 0, 0, 1));
    tbl.push_back(row(1, 5, 0, 1, 0, 0, 0, 0, 2, 0, 0, 1));
    tbl.push_back(row(1, 5, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(row(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // lw x7 ; add x8 <- x7 on source 1: one stall cycle then MEM forward
    tbl.push_back(row(1, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 0, 7, 2, 8, 1, 0, 0, 0, 3, 1, 1));
    tbl.push_back(row(1, 0, 7, 2, 8, 1, 0, 0, 0, 2, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // add x3 ; sub x3 ; read x3 (youngest wins) and x0 while writing x0
    tbl.push_back(row(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(row(1, 3, 0, 3, 0, 1, 0, 0, 3, 0, 0, 2));
    tbl.push_back(row(1, 3, 0, 3, 0, 0, 0, 0, 2, 0, 0, 2));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // flushed add x9 never enters
    tbl.push_back(row(1, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // lw x7 then an invalid ID reading x7: forwards but no stall
    tbl.push_back(row(1, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 7, 2, 0, 0, 0, 0, 0, 3, 0, 1));
    // matching register on an unused source is ignored
    tbl.push_back(row(0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // lw x7 ; stall coinciding with flush gives a single bubble
    tbl.push_back(row(1, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 0, 7, 2, 10, 1, 0, 1, 0, 3, 1, 1));
    tbl.push_back(row(1, 0, 7, 2, 10, 1, 0, 0, 0, 2, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));

    // ---------------- reset state ----------------
    reset = 1'b0;
    drive_a(1'b0, 5'd5, 5'd7, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    drive_b(1'b0, 15'd0, 3'b000, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("reset fwd", a_fwd, 0);
    check("reset stall", a_stall, 0);
    check("reset cnt", a_cnt, 0);
    check("reset fwd5", b_fwd, 0);
    check("reset cnt5", b_cnt, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    drive_a(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("post-reset cnt", a_cnt, 0);
    @(posedge clk); #1;

    // ---------------- vector table ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      drive_a(tbl[i].v, tbl[i].rs0, tbl[i].rs1, tbl[i].used, tbl[i].rd,
              tbl[i].rw, tbl[i].ld, tbl[i].fl);
      @(negedge clk);
      check($sformatf("row%0d fwd0", i), a_fwd[1:0], tbl[i].f0);
      check($sformatf("row%0d fwd1", i), a_fwd[3:2], tbl[i].f1);
      check($sformatf("row%0d stall", i), a_stall, tbl[i].st);
      check($sformatf("row%0d cnt", i), a_cnt, tbl[i].cnt);
      @(posedge clk); #1;
    end

    // ---------------- asynchronous reset mid-operation ----------------
    drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd2, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_a(1'b0, 5'd2, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("pre-reset cnt", a_cnt, 3);
    check("pre-reset fwd0", a_fwd[1:0], 2);
    #2 reset = 1'b0;
    #1;
    check("async reset cnt", a_cnt, 0);
    check("async reset fwd", a_fwd, 0);
    check("async reset stall", a_stall, 0);
    // An instruction presented while reset is held must not load.
    drive_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("held reset cnt", a_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    drive_a(1'b0, 5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("first load fwd0", a_fwd[1:0], 3);
    check("first load cnt", a_cnt, 1);
    @(posedge clk); #1;
    drive_a(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);

    // ---------------- DEPTH=5, LOAD_READY=3, NUM_SRC=3 ----------------
    drive_b(1'b1, 15'd0, 3'b000, 5'd4, 1'b1, 1'b1);            // lw x4
    @(negedge clk);
    check("d5 lw stall", b_stall, 0);
    check("d5 lw cnt", b_cnt, 0);
    @(posedge clk); #1;
    drive_b(1'b1, {5'd4, 5'd0, 5'd0}, 3'b100, 5'd11, 1'b1, 1'b0); // add x11 <- x4
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("d5 stall%0d", k), b_stall, 1);
      check($sformatf("d5 fwd2 stall%0d", k), b_fwd[8:6], 5 - k);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("d5 released stall", b_stall, 0);
    check("d5 released fwd2", b_fwd[8:6], 2);
    check("d5 released cnt", b_cnt, 1);
    @(posedge clk); #1;
    drive_b(1'b1, 15'd0, 3'b000, 5'd12, 1'b1, 1'b1);           // lw x12
    @(negedge clk);
    check("d5 lw12 cnt", b_cnt, 2);
    @(posedge clk); #1;
    drive_b(1'b1, 15'd0, 3'b000, 5'd12, 1'b1, 1'b0);           // add x12
    @(negedge clk);
    check("d5 add12 cnt", b_cnt, 2);
    @(posedge clk); #1;
    drive_b(1'b1, {5'd0, 5'd11, 5'd12}, 3'b011, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("d5 younger add no stall", b_stall, 0);
    check("d5 fwd vector", b_fwd, {3'd0, 3'd3, 3'd5});
    check("d5 cnt3", b_cnt, 3);
    @(posedge clk); #1;
    drive_b(1'b0, 15'd0, 3'b000, 5'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/forwarding_scoreboard.md
FORWARDING_SCOREBOARD -- requirements
Module: forwarding_scoreboard

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NUM_SRC, 2, source-operand ports checked per ID instruction.
REQ-002 DEPTH, 3, forwarding stages tracked (stage 0 = EX, 1 = MEM, 2 = WB, ...); legal range 1..7.
REQ-003 LOAD_READY, 1, first stage index whose load result is forwardable; legal range 0..DEPTH; 0 disables load-use stall.
REQ-004 Derived widths SHALL be SEL_W = clog2(DEPTH+1) and CNT_W = clog2(DEPTH+1).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 id_valid  in  1  ID holds a real instruction.
REQ-008 id_rs  in  NUM_SRC*5  source register addresses, source s at bits [5s+4:5s].
REQ-009 id_rs_used  in  NUM_SRC  source s is actually read.
REQ-010 id_rd  in  5  destination of the ID instruction.
REQ-011 id_reg_write  in  1  ID instruction writes id_rd.
REQ-012 id_is_load  in  1  ID instruction is a load.
REQ-013 flush  in  1  kill the ID instruction (branch mispredict); it does not enter EX.
REQ-014 forward  out  NUM_SRC*SEL_W  per-source select, source s at [SEL_W*s+SEL_W-1:SEL_W*s].
REQ-015 stall  out  1  hold PC/IF/ID, insert bubble into EX.
REQ-016 inflight_writes  out  CNT_W  number of tracked entries with valid and reg_write set.

Function
REQ-017 State SHALL be a DEPTH-entry tag pipeline; each entry = {valid, rd[4:0], wr, ld}.
REQ-018 Every clk edge, entry i SHALL move to entry i+1 for i < DEPTH-1; entry DEPTH-1 is discarded.
REQ-019 Entry 0 SHALL load {1, id_rd, id_reg_write && (id_rd != 0), id_is_load} when id_valid && !stall && !flush; otherwise entry 0 becomes a bubble (all fields 0).
REQ-020 Source s SHALL match entry i when id_rs_used[s], id_rs[s] != 0, entry i valid, wr = 1 and rd == id_rs[s].
REQ-021 forward[s] SHALL equal DEPTH - i for the lowest-index (youngest) matching entry i, and 0 (register file) when none match; with DEPTH = 3 this gives EX = 3, MEM = 2, WB = 1, none = 0.
REQ-022 stall SHALL be 1 iff id_valid and, for some source s, the youngest match i has ld = 1 and i < LOAD_READY.
REQ-023 A stall SHALL be determined only by the youngest match; an older matching load never stalls if a younger non-load matches.
REQ-024 forward and stall SHALL be combinational from state and current inputs; zero-cycle latency.
REQ-025 forward SHALL be computed even while stall = 1; the consumer ignores it that cycle.
REQ-026 flush and stall together SHALL insert a single bubble; flush has no effect on entries 0..DEPTH-1.
REQ-027 A stalled instruction SHALL re-evaluate next cycle against the shifted pipeline; stall lasts exactly LOAD_READY - i cycles.
REQ-028 inflight_writes SHALL be the population count of (valid && wr) over all entries, combinational.
REQ-029 id_rd = 0 with id_reg_write = 1 SHALL enter with wr = 0, never matching and never counted.

Reset
REQ-030 reset low SHALL immediately clear every entry to the bubble state, independent of clk.
REQ-031 While reset is low and after release, until new entries load: forward = 0, inflight_writes = 0, stall = 0.
REQ-032 First entry load SHALL occur on the first rising clk edge with reset high.

Verification
REQ-033 Defaults: issue add x5; next cycle ID reads rs1 = x5 -> forward[0] = 3; one later -> 2; two later -> 1; three later -> 0.
REQ-034 Load-use: issue lw x7; next ID reads rs2 = x7 -> stall = 1 for one cycle, then forward[1] = 2, stall = 0.
REQ-035 Priority: add x3 then sub x3 back-to-back; ID reads x3 -> forward = 3 (sub); x0 read with a prior write to x0 -> forward = 0, inflight_writes unchanged.
REQ-036 flush: issue add x9 with flush = 1; next ID reads x9 -> forward = 0, inflight_writes = 0.
REQ-037 Reset mid-operation: three writes in flight (inflight_writes = 3), drop reset asynchronously between edges -> inflight_writes = 0 and forward = 0 before the next clk edge.
REQ-038 Parameter sweep: DEPTH = 5, LOAD_READY = 3, NUM_SRC = 3; load to x4 then ID reads x4 on source 2 -> stall for 3 cycles, then forward[2] = 2.
